// File: rtl/fp_add_arbiter.sv
// Round-robin front end for one shared pipelined fp adder. Requests are granted
// one per enabled cycle, and a {valid,id} tag pipeline returns each sum to its owner.
module fp_add_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int ID_WIDTH         = 2,
  parameter int FLOAT_DATA_WIDTH = 32,
  parameter int ADD_LATENCY      = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clk_en,
  input  logic [NUM_REQ-1:0]                    req,
  input  logic [NUM_REQ*FLOAT_DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*FLOAT_DATA_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]                    grant,
  output logic                                  add_en,
  output logic [FLOAT_DATA_WIDTH-1:0]           add_a,
  output logic [FLOAT_DATA_WIDTH-1:0]           add_b,
  input  logic [FLOAT_DATA_WIDTH-1:0]           add_result,
  output logic                                  rsp_valid,
  output logic [ID_WIDTH-1:0]                   rsp_id,
  output logic [FLOAT_DATA_WIDTH-1:0]           rsp_data,
  output logic                                  busy
);
  localparam int W = FLOAT_DATA_WIDTH;

  logic [NUM_REQ-1:0][W-1:0]            a_lane, b_lane;
  logic [ID_WIDTH-1:0]                  ptr, winner;
  logic                                 any_req, accept;
  // Entry 0 is the issue slot; entry ADD_LATENCY lines up with add_result.
  logic [ADD_LATENCY:0]                 vld_pipe;
  logic [ADD_LATENCY:0][ID_WIDTH-1:0]   id_pipe;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign a_lane[i] = req_a[i*W +: W];
    assign b_lane[i] = req_b[i*W +: W];
  end

  // First requester at or above ptr, wrapping; index math wraps in ID_WIDTH bits.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_req && req[ptr + ID_WIDTH'(k)]) begin
        any_req = 1'b1;
        winner  = ptr + ID_WIDTH'(k);
      end
    end
  end

  assign accept = any_req & clk_en & ~rst;
  assign add_en = clk_en & ~rst;
  assign busy   = (|vld_pipe) | rsp_valid;

  always_comb begin
    grant = '0;
    if (accept) grant[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      vld_pipe  <= '0;
      id_pipe   <= '0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (clk_en) begin
        vld_pipe <= {vld_pipe[ADD_LATENCY-1:0], accept};
        id_pipe  <= {id_pipe[ADD_LATENCY-1:0], winner};
        if (accept) begin
          ptr   <= winner + 1'b1;
          add_a <= a_lane[winner];
          add_b <= b_lane[winner];
        end
        if (vld_pipe[ADD_LATENCY]) begin
          rsp_valid <= 1'b1;
          rsp_id    <= id_pipe[ADD_LATENCY];
          rsp_data  <= add_result;
        end
      end
    end
  end
endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Round-robin arbiter and scheduler that shares one pipelined single-precision `add` core among `NUM_REQ` requesters, such as the accumulation contexts in the final adder stages. It accepts at most one operand pair per enabled cycle and drives the shared adder with a free-running enable. A tag pipeline of depth `ADD_LATENCY` tracks each operation so every result is returned to the requester that issued it. It replaces the per-stage private adders and `delay` counters with one time-multiplexed adder.

## Interface
- `NUM_REQ`, 4: number of requesters; a power of two, 2..8.
- `ID_WIDTH`, 2: log2(`NUM_REQ`).
- `FLOAT_DATA_WIDTH`, 32: IEEE-754 single-precision operand width.
- `ADD_LATENCY`, 5: enabled cycles from operands on `add_a`/`add_b` to a valid `add_result`.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset; also tied externally to the adder `aclr`.
- `clk_en`  in  1  global advance enable; when low, the block freezes.
- `req`  in  `NUM_REQ`  per-requester request; held high with stable operands until granted.
- `req_a`  in  `NUM_REQ*FLOAT_DATA_WIDTH`  operand A, requester i at bits [i*W +: W].
- `req_b`  in  `NUM_REQ*FLOAT_DATA_WIDTH`  operand B, same packing as `req_a`.
- `grant`  out  `NUM_REQ`  combinational one-hot accept; the pair is consumed on the edge where `req[i] & grant[i]`.
- `add_en`  out  1  adder `clk_en`; equals `clk_en & ~rst`.
- `add_a`  out  `FLOAT_DATA_WIDTH`  registered operand to adder `dataa`.
- `add_b`  out  `FLOAT_DATA_WIDTH`  registered operand to adder `datab`.
- `add_result`  in  `FLOAT_DATA_WIDTH`  adder `result`.
- `rsp_valid`  out  1  one-cycle pulse when a result is returned.
- `rsp_id`  out  `ID_WIDTH`  index of the requester that owns `rsp_data`.
- `rsp_data`  out  `FLOAT_DATA_WIDTH`  returned sum.
- `busy`  out  1  high while any operation is in flight or being returned.

## Operation
- **Arbitration.** The round-robin pointer `ptr` names the highest-priority requester.
  - The winner is the first i with `req[i]=1`, searching from `ptr` upward and wrapping.
  - `grant` is all-zero when `clk_en=0`, when `rst=1`, or when no `req` bit is set.
  - On an accept, `ptr <= winner+1` mod `NUM_REQ`. With no accept, `ptr` holds.
- **Issue.** On an accept edge, `add_a`/`add_b` load the winner's operands, and the issue slot loads {valid=1, id=winner}.
  - On an enabled edge with no accept, the slot loads valid=0 (a bubble), and `add_a`/`add_b` hold their values.
- **Tag pipeline.** The issue slot feeds a shift register of `ADD_LATENCY` {valid, id} entries.
  - The register advances only on `clk_en=1` edges, so entries stay aligned with the adder pipeline.
  - The tail entry corresponds to the current `add_result`.
- **Return.** On an enabled edge where the tail is valid: `rsp_valid <= 1`, `rsp_id <= tail.id`, `rsp_data <= add_result`.
  - On any other edge, `rsp_valid <= 0`, and `rsp_id`/`rsp_data` hold.
- **Ordering.** Results return strictly in issue order. There is no reordering and no back-pressure on responses; requesters must always be able to take `rsp_valid`.
- **Busy.** `busy` = OR of issue-slot valid, all tag-pipeline valids, and `rsp_valid`.
- **Arithmetic.** No arithmetic is performed here; operands pass bit-exact to the adder and results pass bit-exact back.

## Timing
- **Reset values.** On `rst=1` at an edge:
  - `ptr`=0, all valids 0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `add_a`=`add_b`=0, `busy`=0.
  - `grant`=0 and `add_en`=0 combinationally while `rst=1`.
- **Reset mid-operation.** All in-flight operations are discarded and no `rsp_valid` is produced for them. Requesters must reissue.
- **Latency.** Accept in cycle t, with all cycles enabled:
  - `add_a`/`add_b` are valid in cycle t+1.
  - `add_result` is valid in cycle t+1+`ADD_LATENCY`.
  - `rsp_valid` is high in cycle t+2+`ADD_LATENCY`, which is t+7 with the defaults.
- **Throughput.** One accept per enabled cycle. A single requester holding `req` high is granted every cycle, each edge consuming the pair presented that cycle.
- **Stall.** `clk_en=0` cycles freeze `ptr`, the issue slot, the tag pipeline, `add_a`/`add_b` and `rsp_*`. `rsp_valid` is forced low and does not repeat. Latency stretches by exactly the number of stalled cycles.
- **Simultaneous events.** An accept and a return on the same edge are both performed. Reset has priority over everything.

## Test plan
- **Single request.** `req[2]=1`, a=0x3F800000, b=0x40000000 accepted in cycle 10, adder model returns 0x40400000 -> `grant`=4'b0100 in cycle 10 only; `rsp_valid` in cycle 17 with `rsp_id`=2, `rsp_data`=0x40400000; `busy` low from cycle 18.
- **Full contention.** All four `req` held high from reset release -> grants in order 0,1,2,3,0,1...; `rsp_id` sequence 0,1,2,3 on consecutive cycles starting 7 cycles after the first grant.
- **Back-to-back and bubbles.** Requester 1 issues 1.5+0.5, then 1.0+1.0, in adjacent cycles, then idles 3 cycles, then issues 2.0+1.0 -> responses 0x40000000, 0x40000000 on adjacent cycles, then 0x40400000 four cycles later, all with `rsp_id`=1.
- **Stall.** `clk_en` low for 3 cycles, 2 cycles after an accept -> `rsp_valid` delayed to t+10; no `grant`, `add_en`=0 and `rsp_valid`=0 during the stall; a single response pulse.
- **Reset mid-flight.** Three operations in flight, `rst` pulsed 1 cycle -> no `rsp_valid` for them; `ptr` restarts at 0 (with all `req` high, the first grant is 0); `busy`=0 on the cycle after reset.
- **Priority wrap.** `ptr`=3 after a grant to 2, then `req`=4'b0101 -> grant 0, then 2.
